// File: rtl/trdb_pkg.sv
// Shared types for the trace stream arbiter: source codes, flush states and defaults.
package trdb_pkg;

   typedef enum logic [1:0] {
      TRDB_SRC_PKT = 2'd0,
      TRDB_SRC_TIM = 2'd1,
      TRDB_SRC_SW  = 2'd2
   } trdb_src_e;

   typedef enum logic [1:0] {
      TRDB_ST_IDLE  = 2'd0,
      TRDB_ST_DRAIN = 2'd1,
      TRDB_ST_DONE  = 2'd2
   } trdb_flush_e;

   localparam int TRDB_DATA_WIDTH_DEFAULT   = 32;
   localparam int TRDB_STARVE_LIMIT_DEFAULT = 8;

endpackage

// File: rtl/trdb_stream_arbiter_if.sv
// Word-stream bundle between the three sources, the arbiter and the output FIFO.
interface trdb_stream_arbiter_if #(parameter int DATA_WIDTH = 32);

   logic [DATA_WIDTH-1:0] pkt_word_i;
   logic                  pkt_valid_i;
   logic                  pkt_grant_o;
   logic [DATA_WIDTH-1:0] tim_word_i;
   logic                  tim_valid_i;
   logic                  tim_grant_o;
   logic [DATA_WIDTH-1:0] sw_word_i;
   logic                  sw_valid_i;
   logic                  sw_grant_o;
   logic [DATA_WIDTH-1:0] out_word_o;
   logic                  out_valid_o;
   logic                  out_grant_i;
   logic [1:0]            out_src_o;

   modport slave (
      input  pkt_word_i, pkt_valid_i, tim_word_i, tim_valid_i, sw_word_i, sw_valid_i, out_grant_i,
      output pkt_grant_o, tim_grant_o, sw_grant_o, out_word_o, out_valid_o, out_src_o
   );

   modport master (
      output pkt_word_i, pkt_valid_i, tim_word_i, tim_valid_i, sw_word_i, sw_valid_i, out_grant_i,
      input  pkt_grant_o, tim_grant_o, sw_grant_o, out_word_o, out_valid_o, out_src_o
   );

endinterface

// File: rtl/trdb_prio_select.sv
// Combinational 3-way priority picker (pkt > tim > sw) with a software override.
module trdb_prio_select
   import trdb_pkg::*;
(
   input  logic      i_allow,
   input  logic      i_req_pkt,
   input  logic      i_req_tim,
   input  logic      i_req_sw,
   input  logic      i_override_sw,
   output logic      o_gnt_pkt,
   output logic      o_gnt_tim,
   output logic      o_gnt_sw,
   output logic      o_gnt_any,
   output trdb_src_e o_src
);

   always_comb begin
      o_gnt_pkt = 1'b0;
      o_gnt_tim = 1'b0;
      o_gnt_sw  = 1'b0;
      o_src     = TRDB_SRC_PKT;
      if (i_allow) begin
         if (i_override_sw && i_req_sw) begin
            o_gnt_sw = 1'b1;
            o_src    = TRDB_SRC_SW;
         end else if (i_req_pkt) begin
            o_gnt_pkt = 1'b1;
            o_src     = TRDB_SRC_PKT;
         end else if (i_req_tim) begin
            o_gnt_tim = 1'b1;
            o_src     = TRDB_SRC_TIM;
         end else if (i_req_sw) begin
            o_gnt_sw = 1'b1;
            o_src    = TRDB_SRC_SW;
         end
      end
      o_gnt_any = o_gnt_pkt | o_gnt_tim | o_gnt_sw;
   end

endmodule

// File: rtl/trdb_stream_arbiter.sv
// Merges pkt/tim/sw words into one registered stream with a flush sequencer.
// Optional software starvation guard: define TRDB_ARB_STARVE_GUARD_EN.
module trdb_stream_arbiter
   import trdb_pkg::*;
#(
   parameter int DATA_WIDTH   = TRDB_DATA_WIDTH_DEFAULT,
   parameter int STARVE_LIMIT = TRDB_STARVE_LIMIT_DEFAULT
)
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic enable_i,
   input  logic flush_req_i,
   output logic flush_confirm_o,
   output logic busy_o,
   trdb_stream_arbiter_if.slave bus
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
      $error("trdb_stream_arbiter: STARVE_LIMIT must be within 1..255");
   end

   trdb_flush_e           r_state;
   trdb_flush_e           w_state_next;
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_word;
   trdb_src_e             r_out_src;

   logic                  w_slot_free;
   logic                  w_allow;
   logic                  w_req_tim;
   logic                  w_req_sw;
   logic                  w_override;
   logic                  w_gnt_pkt;
   logic                  w_gnt_tim;
   logic                  w_gnt_sw;
   logic                  w_gnt_any;
   trdb_src_e             w_gnt_src;
   logic [DATA_WIDTH-1:0] w_next_word;

   // No grants during reset or the confirm cycle; only pkt may drain during a flush.
   assign w_slot_free = ~r_out_valid | bus.out_grant_i;
   assign w_allow     = w_slot_free & enable_i & ~rst_i & (r_state != TRDB_ST_DONE);
   assign w_req_tim   = bus.tim_valid_i & (r_state == TRDB_ST_IDLE);
   assign w_req_sw    = bus.sw_valid_i & (r_state == TRDB_ST_IDLE);

`ifdef TRDB_ARB_STARVE_GUARD_EN
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
   logic [7:0] r_starve_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_starve_cnt <= 8'd0;
      end else if (!bus.sw_valid_i || w_gnt_sw) begin
         r_starve_cnt <= 8'd0;
      end else if (r_state == TRDB_ST_IDLE && w_allow && r_starve_cnt != LIMIT) begin
         r_starve_cnt <= r_starve_cnt + 8'd1;
      end
   end

   assign w_override = bus.sw_valid_i & (r_starve_cnt == LIMIT);
`else
   assign w_override = 1'b0;
`endif

   trdb_prio_select u_prio (
      .i_allow       (w_allow),
      .i_req_pkt     (bus.pkt_valid_i),
      .i_req_tim     (w_req_tim),
      .i_req_sw      (w_req_sw),
      .i_override_sw (w_override),
      .o_gnt_pkt     (w_gnt_pkt),
      .o_gnt_tim     (w_gnt_tim),
      .o_gnt_sw      (w_gnt_sw),
      .o_gnt_any     (w_gnt_any),
      .o_src         (w_gnt_src)
   );

   always_comb begin
      w_next_word = bus.pkt_word_i;
      case (w_gnt_src)
         TRDB_SRC_TIM: w_next_word = bus.tim_word_i;
         TRDB_SRC_SW:  w_next_word = bus.sw_word_i;
         default:      w_next_word = bus.pkt_word_i;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_out_valid <= 1'b0;
         r_out_word  <= '0;
         r_out_src   <= TRDB_SRC_PKT;
      end else if (w_gnt_any) begin
         r_out_valid <= 1'b1;
         r_out_word  <= w_next_word;
         r_out_src   <= w_gnt_src;
      end else if (bus.out_grant_i) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= TRDB_ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Flush completes once the pkt source is quiet and the output register is empty.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         TRDB_ST_IDLE:  if (flush_req_i) w_state_next = TRDB_ST_DRAIN;
         TRDB_ST_DRAIN: if (!bus.pkt_valid_i && !r_out_valid) w_state_next = TRDB_ST_DONE;
         TRDB_ST_DONE:  w_state_next = TRDB_ST_IDLE;
         default:       w_state_next = TRDB_ST_IDLE;
      endcase
   end

   assign bus.pkt_grant_o = w_gnt_pkt;
   assign bus.tim_grant_o = w_gnt_tim;
   assign bus.sw_grant_o  = w_gnt_sw;
   assign bus.out_word_o  = r_out_word;
   assign bus.out_valid_o = r_out_valid;
   assign bus.out_src_o   = r_out_src;
   assign flush_confirm_o = (r_state == TRDB_ST_DONE);
   assign busy_o          = r_out_valid | (r_state != TRDB_ST_IDLE);

endmodule
